// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS      = 8;
    localparam int DEFAULT_CLK_DIV = 868;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO; push is ignored when full, pop is ignored when empty.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_bi,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_bo,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_bo
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign full_o   = (count == (AW+1)'(DEPTH));
    assign empty_o  = (count == '0);
    assign count_bo = count;
    assign data_bo  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_bi;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1/8N2 UART transmitter: byte FIFO in front of a frame FSM and shifter.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [7:0] data_bi,
    output logic       ack_o,
    output logic       full_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q;
    logic             line;
    logic             pop;
    logic             baud_last;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;

    assign ack_o     = req_i && !fifo_full && !rst_i;
    assign full_o    = fifo_full;
    assign busy_o    = (state_q != IDLE) || (fifo_count != '0);
    assign tx_o      = tx_q;
    assign baud_last = (baud_cnt_q == CNT_W'(CLK_DIV - 1));

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (ack_o),
        .data_bi  (data_bi),
        .pop_i    (pop),
        .data_bo  (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_bo (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        line       = 1'b1;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_head;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                line = 1'b0;
                if (baud_last) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                line = shift_q[bit_idx_q];
                if (baud_last) begin
                    if (bit_idx_q == 3'(FRAME_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // bit_idx doubles as the stop-bit counter; chaining straight into
                // START keeps back-to-back frames gapless.
                if (baud_last) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line is registered from the current state, so tx_o trails the FSM by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= line;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench: records tx_o each cycle and compares against hand-built frame traces.
module tb_uart_tx_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       ack_a, full_a, busy_a, tx_a;
    logic       ack_b, full_b, busy_b, tx_b;
    logic       ack_c, full_c, busy_c, tx_c;

    int         total = 0;
    int         bad   = 0;
    int         sel   = 0;
    logic       trace[$];
    logic       exp_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx_buf #(.CLK_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_bi(data),
        .ack_o(ack_a), .full_o(full_a), .busy_o(busy_a), .tx_o(tx_a));

    uart_tx_buf #(.CLK_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_bi(data),
        .ack_o(ack_b), .full_o(full_b), .busy_o(busy_b), .tx_o(tx_b));

    uart_tx_buf #(.CLK_DIV(868), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_bi(data),
        .ack_o(ack_c), .full_o(full_c), .busy_o(busy_c), .tx_o(tx_c));

    function automatic logic cur_tx();
        case (sel)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic cur_ack();
        case (sel)
            0:       return ack_a;
            1:       return ack_b;
            default: return ack_c;
        endcase
    endfunction

    function automatic logic cur_busy();
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic cur_full();
        case (sel)
            0:       return full_a;
            1:       return full_b;
            default: return full_c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        trace.push_back(cur_tx());
    endtask

    task automatic run_to(input int n);
        while (trace.size() < n) tick();
    endtask

    task automatic add_level(input logic v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input int div, input int stops);
        add_level(1'b0, div);
        for (int k = 0; k < 8; k++) add_level(b[k], div);
        add_level(1'b1, stops * div);
    endtask

    task automatic cmp_trace(input string tag, input int div);
        int mism;
        check({tag, "_len"}, trace.size(), exp_q.size());
        for (int s = 0; s < exp_q.size(); s += div) begin
            mism = 0;
            for (int j = s; j < s + div && j < exp_q.size() && j < trace.size(); j++)
                if (trace[j] !== exp_q[j]) mism++;
            check($sformatf("%s_seg%0d", tag, s), mism, 0);
        end
    endtask

    // Receiver model: find a falling edge, sample mid-bit.
    task automatic decode(input int div);
        int         i;
        int         mid;
        logic [7:0] b;
        rx_q.delete();
        i = 0;
        while (i < trace.size()) begin
            if (trace[i] === 1'b0) begin
                mid = i + div / 2;
                if (mid + 9 * div >= trace.size()) break;
                for (int k = 0; k < 8; k++) b[k] = trace[mid + (k + 1) * div];
                rx_q.push_back(b);
                i = mid + 9 * div;
            end else begin
                i++;
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst  = 1'b1;
        req  = 1'b1;
        data = 8'h5A;
        #1 check("ack_in_rst", cur_ack(), 1'b0);
        tick();
        tick();
        check("rst_tx", cur_tx(), 1'b1);
        check("rst_busy", cur_busy(), 1'b0);
        check("rst_full", cur_full(), 1'b0);
        rst = 1'b0;
        req = 1'b0;
    endtask

    task automatic start_scenario();
        trace.delete();
        exp_q.delete();
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic want_ack, input string tag);
        req  = 1'b1;
        data = b;
        #1 check(tag, cur_ack(), want_ack);
        tick();
    endtask

    task automatic run_single(input string tag, input logic [7:0] b, input int div,
                              input int stops, input bit reset_first);
        if (reset_first) do_reset();
        start_scenario();
        push_byte(b, 1'b1, {tag, "_ack"});
        req = 1'b0;
        check({tag, "_busy_on"}, cur_busy(), 1'b1);
        add_level(1'b1, 3);
        add_frame(b, div, stops);
        add_level(1'b1, 4);
        run_to(exp_q.size());
        cmp_trace(tag, div);
        check({tag, "_busy_off"}, cur_busy(), 1'b0);
        decode(div);
        check({tag, "_rx_n"}, rx_q.size(), 1);
        if (rx_q.size() >= 1) check({tag, "_rx"}, rx_q[0], b);
    endtask

    initial begin
        logic [7:0] burst[3];
        rst  = 1'b1;
        req  = 1'b0;
        data = 8'h00;

        // Single byte from idle, 8N1, divider 4
        sel = 0;
        run_single("f55", 8'h55, 4, 1, 1'b1);

        // Three back-to-back writes
        do_reset();
        start_scenario();
        burst[0] = 8'hA3; burst[1] = 8'h0F; burst[2] = 8'hFF;
        for (int k = 0; k < 3; k++) push_byte(burst[k], 1'b1, $sformatf("burst_ack%0d", k));
        req = 1'b0;
        add_level(1'b1, 3);
        for (int k = 0; k < 3; k++) add_frame(burst[k], 4, 1);
        add_level(1'b1, 4);
        run_to(exp_q.size());
        cmp_trace("burst", 4);
        check("burst_busy_off", cur_busy(), 1'b0);
        decode(4);
        check("burst_rx_n", rx_q.size(), 3);
        for (int k = 0; k < 3 && k < rx_q.size(); k++)
            check($sformatf("burst_rx%0d", k), rx_q[k], burst[k]);

        // Overfill: six requests, five accepted
        do_reset();
        start_scenario();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check("ovf_full", cur_full(), 1'b1);
            push_byte(8'((k + 1) * 8'h11), (k < 5), $sformatf("ovf_ack%0d", k));
        end
        req = 1'b0;
        add_level(1'b1, 3);
        for (int k = 0; k < 5; k++) add_frame(8'((k + 1) * 8'h11), 4, 1);
        add_level(1'b1, 4);
        run_to(exp_q.size());
        cmp_trace("ovf", 4);
        decode(4);
        check("ovf_rx_n", rx_q.size(), 5);
        for (int k = 0; k < 5 && k < rx_q.size(); k++)
            check($sformatf("ovf_rx%0d", k), rx_q[k], 8'((k + 1) * 8'h11));

        // Reset mid-frame with a second byte still buffered
        do_reset();
        start_scenario();
        push_byte(8'h00, 1'b1, "abort_ack0");
        push_byte(8'h5A, 1'b1, "abort_ack1");
        req = 1'b0;
        run_to(19);
        rst = 1'b1;
        tick();
        check("abort_tx", cur_tx(), 1'b1);
        check("abort_busy", cur_busy(), 1'b0);
        check("abort_full", cur_full(), 1'b0);
        rst = 1'b0;
        add_level(1'b1, 3);
        add_level(1'b0, 16);
        add_level(1'b1, 60);
        run_to(exp_q.size());
        cmp_trace("abort", 4);
        run_single("f81", 8'h81, 4, 1, 1'b0);

        // Two stop bits
        sel = 1;
        run_single("fc3", 8'hC3, 4, 2, 1'b1);

        // Full-rate divider
        sel = 2;
        run_single("f41", 8'h41, 868, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
